// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller.
//               - Data-memory FSM state encoding.
//               - EX operand forwarding select codes.
//               - Scoreboard entry layout.
//               - Helper that tests whether an entry writes a given register.
// Revision    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Register-index width held in every scoreboard entry. The top-level
  // REG_AW port width is cast into this field width.
  localparam int unsigned SB_AW = 5;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] rs1;
    logic [SB_AW-1:0] rs2;
    logic             use1;
    logic             use2;
    logic [SB_AW-1:0] rd;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
  } sb_entry_t;

  // True when entry e will write register idx. x0 never counts as a write.
  function automatic logic writes_reg(input sb_entry_t e, input logic [SB_AW-1:0] idx);
    return e.valid & e.reg_write & (e.rd != '0) & (e.rd == idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_fwd_unit
// Description : Purely combinational forwarding select and load-use detect.
// Ports       : ex_e/mem_e/wb_e  - scoreboard entries of the EX/MEM/WB stages
//               id_valid         - ID holds a real instruction
//               id_rs1/id_rs2    - ID source indices
//               id_use_rs1/2     - ID actually reads the source
//               fwd_a/fwd_b      - EX operand selects (REG/MEM/WB)
//               load_use         - ID needs the result of the load now in EX
// Revision    : 1.0  initial release
// ============================================================================
module hazard_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  sb_entry_t        ex_e,
  input  sb_entry_t        mem_e,
  input  sb_entry_t        wb_e,
  input  logic             id_valid,
  input  logic [SB_AW-1:0] id_rs1,
  input  logic [SB_AW-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             load_use
);

  logic ld_in_ex;

  // Fields not needed for forwarding or load-use matching.
  logic w_unused;
  assign w_unused = ^{ex_e.reg_write, ex_e.mem_write,
                      mem_e.rs1, mem_e.rs2, mem_e.use1, mem_e.use2,
                      mem_e.mem_read, mem_e.mem_write,
                      wb_e.rs1, wb_e.rs2, wb_e.use1, wb_e.use2,
                      wb_e.mem_read, wb_e.mem_write};

  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;

    // The younger producer (MEM) holds the newer value, so it is tested first.
    if (ex_e.use1 && writes_reg(mem_e, ex_e.rs1)) begin
      fwd_a = FWD_MEM;
    end else if (ex_e.use1 && writes_reg(wb_e, ex_e.rs1)) begin
      fwd_a = FWD_WB;
    end

    if (ex_e.use2 && writes_reg(mem_e, ex_e.rs2)) begin
      fwd_b = FWD_MEM;
    end else if (ex_e.use2 && writes_reg(wb_e, ex_e.rs2)) begin
      fwd_b = FWD_WB;
    end

    // A load result is only available after MEM, so an ID reader of it
    // must wait one cycle. x0 is excluded.
    ld_in_ex = ex_e.valid & ex_e.mem_read & (ex_e.rd != '0);
    load_use = id_valid & ld_in_ex &
               ((id_use_rs1 & (id_rs1 == ex_e.rd)) |
                (id_use_rs2 & (id_rs2 == ex_e.rd)));
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Central sequencer for a 5-stage RISC-V pipeline. Keeps a
//               registered scoreboard of the EX/MEM/WB occupants and drives
//               stage enables/flushes, load-use bubbles, redirect kills, EX
//               forwarding selects and the data-memory req/ack wait FSM.
// Ports       : clk, rst (sync, active high)
//               id_*            - decoded ID-stage instruction fields
//               ex_redirect     - EX resolved a taken branch/jump
//               dmem_ack        - data memory completes the current access
//               *_en            - stage register enables
//               if_id_flush, id_ex_flush - load a bubble into the stage reg
//               fwd_a, fwd_b    - EX operand selects (00 reg, 01 MEM, 10 WB)
//               dmem_req        - MEM occupant requests data memory
//               mem_err         - sticky data-memory timeout
//               stall_cycles, flush_events - present only with HAZ_PERF_CNT_EN
// Options     : HAZ_PERF_CNT_EN adds the two 32-bit performance counters.
// Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MEM_TO_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              ex_redirect,
  input  logic              dmem_ack,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              dmem_req,
  output logic              mem_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events
`endif
);

  sb_entry_t ex_q,  ex_d;
  sb_entry_t mem_q, mem_d;
  sb_entry_t wb_q,  wb_d;
  state_e    state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic [7:0]       cnt_inc;
  logic             mem_access;
  logic             req_raw;
  logic             freeze;
  logic             redirect;
  logic             load_use;
  logic [1:0]       fwd_a_raw;
  logic [1:0]       fwd_b_raw;
  logic [SB_AW-1:0] id_rs1_w;
  logic [SB_AW-1:0] id_rs2_w;
  logic [SB_AW-1:0] id_rd_w;

  assign id_rs1_w = SB_AW'(id_rs1);
  assign id_rs2_w = SB_AW'(id_rs2);
  assign id_rd_w  = SB_AW'(id_rd);

  hazard_fwd_unit u_hazard_fwd (
    .ex_e       (ex_q),
    .mem_e      (mem_q),
    .wb_e       (wb_q),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1_w),
    .id_rs2     (id_rs2_w),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .fwd_a      (fwd_a_raw),
    .fwd_b      (fwd_b_raw),
    .load_use   (load_use)
  );

  // --------------------------------------------------------------------------
  // Memory wait FSM and stage control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cnt_inc    = cnt_q + 8'd1;
    freeze     = 1'b0;
    mem_access = mem_q.valid & (mem_q.mem_read | mem_q.mem_write);
    req_raw    = ((state_q == ST_RUN) & mem_access) | (state_q == ST_WAIT);
    redirect   = ex_redirect & ex_q.valid;

    unique case (state_q)
      ST_RUN: begin
        // A same-cycle ack is a zero-wait access; only a miss freezes.
        if (req_raw && !dmem_ack) begin
          freeze  = 1'b1;
          state_d = ST_WAIT;
          cnt_d   = 8'd0;
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          // The pipeline advances in the ack cycle itself.
          state_d = ST_RUN;
          cnt_d   = 8'd0;
        end else begin
          freeze = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_inc == 8'(MEM_TO_MAX)) begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        freeze = 1'b1;
      end
      default: begin
        freeze  = 1'b1;
        state_d = ST_RUN;
      end
    endcase

    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    dmem_req    = req_raw;
    fwd_a       = fwd_a_raw;
    fwd_b       = fwd_b_raw;

    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      dmem_req    = 1'b0;
      fwd_a       = FWD_REG;
      fwd_b       = FWD_REG;
    end else if (freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (redirect) begin
      // Kill the two younger instructions in IF/ID and ID/EX.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      // Hold IF and ID, push one bubble into EX.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end

    // Scoreboard shifts with the stage register enables.
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (id_ex_en) begin
      ex_d.valid     = id_valid & ~id_ex_flush;
      ex_d.rs1       = id_rs1_w;
      ex_d.rs2       = id_rs2_w;
      ex_d.use1      = id_use_rs1;
      ex_d.use2      = id_use_rs2;
      ex_d.rd        = id_rd_w;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      ex_d.mem_write = id_mem_write;
    end
    if (ex_mem_en) begin
      mem_d = ex_q;
    end
    if (mem_wb_en) begin
      wb_d = mem_q;
    end
  end

  assign mem_err = (state_q == ST_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= ST_RUN;
      cnt_q   <= 8'd0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Performance counters (wrap naturally at 2^32)
  // --------------------------------------------------------------------------
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_en) begin
      stall_d = stall_q + 32'd1;
    end
    if (!freeze && redirect) begin
      flush_d = flush_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`endif

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). It sits beside the ID-stage decoder and takes the decoded rd, reg-write and mem-access bits. It keeps its own registered scoreboard of the EX/MEM/WB occupants. From that it drives per-stage enables and flushes, load-use bubbles, branch/jump redirect flushes, EX operand forwarding selects, and the data-memory req/ack wait state machine.

Parameters:
REG_AW, 5, register-index width
MEM_TO_MAX, 15, max dmem wait cycles before sticky error (1..255)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1/id_rs2  in  REG_AW  ID source indices
id_use_rs1/id_use_rs2  in  1  ID actually reads rs1/rs2
id_rd  in  REG_AW  ID destination
id_reg_write  in  1  decoded write-back enable
id_mem_read  in  1  decoded load
id_mem_write  in  1  decoded store
ex_redirect  in  1  EX resolved taken branch/jal/jalr
dmem_ack  in  1  data memory completes the current access
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  stage register enables
if_id_flush, id_ex_flush  out  1  load bubble (NOP) into the stage register
fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 MEM result, 10 WB result
dmem_req  out  1  MEM occupant requests data memory
mem_err  out  1  sticky timeout flag

Behaviour:
- Scoreboard, one entry per stage EX/MEM/WB, each holding {valid, rs1, rs2, use1, use2, rd, reg_write, mem_read, mem_write}.
  - On id_ex_en the EX entry loads the ID fields, with valid = id_valid & ~id_ex_flush.
  - On ex_mem_en the MEM entry loads from EX; on mem_wb_en the WB entry loads from MEM.
- dmem_req = MEM.valid & (mem_read | mem_write) & state==RUN, or state==WAIT. Combinational from registered state.
- FSM states: RUN, WAIT, ERR.
  - RUN, when dmem_req & ~dmem_ack: go to WAIT, clear the counter. All *_en=0 this cycle (full freeze).
  - RUN, when the request is acked in the same cycle: zero-wait, no freeze.
  - WAIT: all *_en=0 and the counter increments each cycle. dmem_ack returns to RUN, and the pipeline advances in that ack cycle. If the counter reaches MEM_TO_MAX with no ack: go to ERR.
  - ERR: mem_err=1, all *_en=0, dmem_req=0. Leaves only via rst.
- Hazards, evaluated in RUN when not frozen. Priority: freeze > redirect > load-use.
  - Redirect (ex_redirect & EX.valid): pc_en=1, if_id_flush=1, id_ex_flush=1, others enabled. Two-instruction kill.
  - Load-use applies when EX.valid & EX.mem_read & EX.rd!=0 and EX.rd matches (id_rs1 & id_use_rs1) or (id_rs2 & id_use_rs2), with id_valid. Response: pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1, ex_mem_en/mem_wb_en=1. Exactly one bubble per load.
  - Otherwise all enables=1 and flushes=0.
- Forwarding for fwd_a (fwd_b identical with rs2/use2):
  - 01 if MEM.valid & MEM.reg_write & MEM.rd!=0 & MEM.rd==EX.rs1 & EX.use1.
  - Else 10 under the same test against WB.
  - Else 00. MEM beats WB.
- x0 never forwards and never stalls.
- Reset: all entries invalid, state RUN, counter 0, mem_err 0.
  - While rst=1: all *_en=0, if_id_flush=id_ex_flush=1, dmem_req=0, fwd_a=fwd_b=00.
  - Reset during WAIT or ERR drops the request immediately.
- Latency: all outputs are combinational from registered state plus the current ID/ex_redirect/dmem_ack inputs. No output register stage.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: adds outputs stall_cycles[31:0] and flush_events[31:0].
  - stall_cycles counts cycles with pc_en=0 outside reset.
  - flush_events counts redirect cycles.
  - Both wrap at 2^32 and clear on rst.
- Undefined: the ports and logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - FSM state encoding (RUN=2'd0, WAIT=2'd1, ERR=2'd2).
  - FWD_REG/FWD_MEM/FWD_WB constants.
  - Scoreboard-entry struct typedef.
- One natural sub-module, hazard_fwd_unit: purely combinational forwarding and load-use match. The FSM and scoreboard registers stay in the top.

Test Plan:
- Forwarding: add x5 then add x6,x5,x5 back-to-back. Required: fwd_a=fwd_b=01 in EX of the second, no stall. With one instruction between them: 10.
- Load-use: lw x7 then add x8,x7,x1. Required: exactly one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; fwd_a=10 afterwards. lw x0 followed by a use of x0 gives no stall.
- Redirect plus load-use in the same cycle: redirect wins. if_id_flush=id_ex_flush=1, pc_en=1.
- Memory wait: lw with dmem_ack held low for 3 cycles. Required: all *_en=0 for those 3 cycles with dmem_req=1; ack in cycle 4 advances all stages. Ack in the request cycle gives no freeze.
- Timeout: with MEM_TO_MAX=4 and ack never asserted, mem_err rises after 4 WAIT cycles and stays. Later acks are ignored; rst clears it.
- Reset mid-WAIT: rst asserted on WAIT cycle 2. Required: dmem_req=0 in that same cycle. After release, state RUN, entries invalid, first instruction flows with fwd=00.
